// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and address-field helpers for the data cache.
// Byte address layout: [tag | index | offset | 2'b00].
package cache_pkg;

  localparam int CACHE_DATA_WIDTH     = 32;
  localparam int CACHE_ADDRESS_WIDTH  = 32;
  localparam int CACHE_SETS           = 16;
  localparam int CACHE_WORDS_PER_LINE = 4;

  localparam int OFFSET_BITS = $clog2(CACHE_WORDS_PER_LINE);
  localparam int INDEX_BITS  = $clog2(CACHE_SETS);
  localparam int TAG_BITS    = CACHE_ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [CACHE_ADDRESS_WIDTH-1:0] a);
    return a[OFFSET_BITS+1:2];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [CACHE_ADDRESS_WIDTH-1:0] a);
    return a[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [CACHE_ADDRESS_WIDTH-1:0] a);
    return a[CACHE_ADDRESS_WIDTH-1:INDEX_BITS+OFFSET_BITS+2];
  endfunction

  function automatic logic [CACHE_ADDRESS_WIDTH-1:0] line_base(input logic [CACHE_ADDRESS_WIDTH-1:0] a);
    return {a[CACHE_ADDRESS_WIDTH-1:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
  endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational read of one line word, a word write port
// and a tag/valid write port. Only the valid bits are reset.
module cache_array
  import cache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [INDEX_BITS-1:0]       rd_index_i,
  input  logic [OFFSET_BITS-1:0]      rd_offset_i,
  output logic                        rd_valid_o,
  output logic [TAG_BITS-1:0]         rd_tag_o,
  output logic [CACHE_DATA_WIDTH-1:0] rd_data_o,
  input  logic                        word_we_i,
  input  logic [INDEX_BITS-1:0]       word_index_i,
  input  logic [OFFSET_BITS-1:0]      word_offset_i,
  input  logic [CACHE_DATA_WIDTH-1:0] word_data_i,
  input  logic                        line_we_i,
  input  logic [INDEX_BITS-1:0]       line_index_i,
  input  logic [TAG_BITS-1:0]         line_tag_i
);

  logic [CACHE_SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]         tag_q  [CACHE_SETS];
  logic [CACHE_DATA_WIDTH-1:0] data_q [CACHE_SETS][CACHE_WORDS_PER_LINE];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[line_index_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (line_we_i) tag_q[line_index_i] <= line_tag_i;
    if (word_we_i) data_q[word_index_i][word_offset_i] <= word_data_i;
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a registered
// req/ack backing-memory port and multi-beat line refill.
module data_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = CACHE_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = CACHE_ADDRESS_WIDTH,
  parameter int SETS           = CACHE_SETS,
  parameter int WORDS_PER_LINE = CACHE_WORDS_PER_LINE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
);

  state_t                   state_q;
  logic [OFFSET_BITS-1:0]   beat_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     mem_req_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;

  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic                     rd_valid;
  logic [TAG_BITS-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     hit;
  logic                     ack;
  logic                     last_beat;
  logic [OFFSET_BITS-1:0]   beat_inc;
  logic                     word_we;
  logic                     line_we;
  logic [OFFSET_BITS-1:0]   word_offset;
  logic [DATA_WIDTH-1:0]    word_data;

  // In IDLE the lookup serves the live CPU address; otherwise the held transaction.
  assign rd_addr   = (state_q == ST_IDLE) ? cpu_addr : addr_q;
  assign hit       = rd_valid && (rd_tag == addr_tag(rd_addr));
  assign ack       = mem_ack && mem_req_q;
  assign last_beat = (beat_q == OFFSET_BITS'(WORDS_PER_LINE - 1));
  assign beat_inc  = beat_q + 1'b1;

  assign word_we     = ack && ((state_q == ST_REFILL) || ((state_q == ST_WRITE) && hit));
  assign line_we     = ack && (state_q == ST_REFILL) && last_beat;
  assign word_offset = (state_q == ST_REFILL) ? beat_q : addr_offset(addr_q);
  assign word_data   = (state_q == ST_REFILL) ? mem_rdata : mem_wdata_q;

  cache_array u_array (
    .clk_i         (clk),
    .rst_ni        (rst),
    .rd_index_i    (addr_index(rd_addr)),
    .rd_offset_i   (addr_offset(rd_addr)),
    .rd_valid_o    (rd_valid),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .word_we_i     (word_we),
    .word_index_i  (addr_index(addr_q)),
    .word_offset_i (word_offset),
    .word_data_i   (word_data),
    .line_we_i     (line_we),
    .line_index_i  (addr_index(addr_q)),
    .line_tag_i    (addr_tag(addr_q))
  );

  always_comb begin
    stall     = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_we) begin
          stall = 1'b1;
        end else if (cpu_re) begin
          if (hit) cpu_rdata = rd_data;
          else     stall     = 1'b1;
        end
      end
      ST_REFILL: stall = 1'b1;
      ST_WRITE:  stall = !mem_ack;
      default:   stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      addr_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_we) begin
            addr_q      <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata_q <= cpu_wdata;
            state_q     <= ST_WRITE;
          end else if (cpu_re && !hit) begin
            addr_q     <= line_base(cpu_addr);
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= line_base(cpu_addr);
            state_q    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (ack) begin
            beat_q <= beat_inc;
            // Beat number replaces the offset field, so the index is never disturbed.
            mem_addr_q <= {addr_q[ADDRESS_WIDTH-1:OFFSET_BITS+2], beat_inc, 2'b00};
            if (last_beat) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          if (ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: refill, hit, write-through, eviction,
// write miss and reset during refill, against a small backing-memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  // Backing memory: unwritten words read back as {16'hC0DE, addr[15:0]}.
  logic [31:0] mem_store [logic [31:0]];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] ack_addr_q[$];
  logic        ack_we_q[$];
  logic [31:0] exp_q[$];

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] v;
    v = {16'hC0DE, a[15:0]};
    if (mem_store.exists(a)) v = mem_store[a];
    return v;
  endfunction

  // Memory responder: acks ack_delay cycles after each beat is presented.
  always @(negedge clk) begin
    if (!rst || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_read(mem_addr);
      if (mem_we) mem_store[mem_addr] = mem_wdata;
      ack_addr_q.push_back(mem_addr);
      ack_we_q.push_back(mem_we);
      wait_cnt = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = wait_cnt + 1;
    end
  end

  // Driver: one CPU access held until stall drops; returns stall count and read data.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, output int stalls, output logic [31:0] rdata);
    ack_delay = delay;
    ack_addr_q.delete();
    ack_we_q.delete();
    stalls = 0;
    rdata  = 'x;
    @(posedge clk); #1;
    cpu_we    = we;
    cpu_re    = !we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    forever begin
      @(negedge clk); #2;
      if (!stall) begin
        rdata = cpu_rdata;
        break;
      end
      stalls++;
      if (stalls > 50) break;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b expected 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    n_tests++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
  endtask

  // Read miss refill of 0x100, single-cycle ack.
  task automatic test_refill();
    int          st;
    logic [31:0] rd;
    do_access(1'b0, 32'h100, 32'h0, 0, st, rd);
    n_tests++; if (st != 5) begin n_fail++; $display("FAIL refill_stall_cycles: got %0d expected 5", st); end
    n_tests++; if (rd !== 32'hC0DE0100) begin n_fail++; $display("FAIL refill_rdata: got %h expected c0de0100", rd); end
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    n_tests++; if (ack_addr_q.size() != 4) begin n_fail++; $display("FAIL refill_beats: got %0d expected 4", ack_addr_q.size()); end
    for (int i = 0; i < 4 && i < ack_addr_q.size(); i++) begin
      n_tests++; if (ack_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL refill_addr%0d: got %h expected %h", i, ack_addr_q[i], exp_q[i]); end
      n_tests++; if (ack_we_q[i] !== 1'b0) begin n_fail++; $display("FAIL refill_we%0d: got %0b expected 0", i, ack_we_q[i]); end
    end
  endtask

  task automatic test_hit();
    int          st;
    logic [31:0] rd;
    do_access(1'b0, 32'h108, 32'h0, 0, st, rd);
    n_tests++; if (st != 0) begin n_fail++; $display("FAIL hit_stall_cycles: got %0d expected 0", st); end
    n_tests++; if (rd !== 32'hC0DE0108) begin n_fail++; $display("FAIL hit_rdata: got %h expected c0de0108", rd); end
    n_tests++; if (ack_addr_q.size() != 0) begin n_fail++; $display("FAIL hit_mem_traffic: got %0d beats expected 0", ack_addr_q.size()); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_mem_req: got %0b expected 0", mem_req); end
  endtask

  // Write hit to 0x104 with ack three cycles late; cycle-by-cycle check.
  task automatic test_write_hit();
    int          st;
    logic [31:0] rd;
    ack_delay = 3;
    ack_addr_q.delete();
    ack_we_q.delete();
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'h104; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk); #2;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL write_issue_stall: got %0b expected 1", stall); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL write_req%0d: got %0b expected 1", i, mem_req); end
      n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL write_we%0d: got %0b expected 1", i, mem_we); end
      n_tests++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL write_addr%0d: got %h expected 104", i, mem_addr); end
      n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_wdata%0d: got %h expected deadbeef", i, mem_wdata); end
      n_tests++; if (stall !== (i != 3)) begin n_fail++; $display("FAIL write_stall%0d: got %0b expected %0b", i, stall, (i != 3)); end
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk); #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL write_req_drop: got %0b expected 0", mem_req); end
    do_access(1'b0, 32'h104, 32'h0, 0, st, rd);
    n_tests++; if (st != 0) begin n_fail++; $display("FAIL write_readback_stall: got %0d expected 0", st); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_readback_rdata: got %h expected deadbeef", rd); end
  endtask

  // 0x200 shares index 0 with 0x100; each evicts the other.
  task automatic test_evict();
    int          st;
    logic [31:0] rd;
    do_access(1'b0, 32'h200, 32'h0, 0, st, rd);
    n_tests++; if (st != 5) begin n_fail++; $display("FAIL evict_200_stall: got %0d expected 5", st); end
    n_tests++; if (rd !== 32'hC0DE0200) begin n_fail++; $display("FAIL evict_200_rdata: got %h expected c0de0200", rd); end
    n_tests++; if (ack_addr_q.size() != 4 || ack_addr_q[0] !== 32'h200 || ack_addr_q[3] !== 32'h20C) begin
      n_fail++; $display("FAIL evict_200_addrs: got %0d beats expected 4 beats 200..20c", ack_addr_q.size());
    end
    do_access(1'b0, 32'h104, 32'h0, 0, st, rd);
    n_tests++; if (st != 5) begin n_fail++; $display("FAIL evict_100_stall: got %0d expected 5", st); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL evict_100_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_write_miss();
    int          st;
    logic [31:0] rd;
    do_access(1'b1, 32'h300, 32'h12345678, 0, st, rd);
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL wmiss_stall: got %0d expected 1", st); end
    n_tests++; if (ack_addr_q.size() != 1) begin n_fail++; $display("FAIL wmiss_beats: got %0d expected 1", ack_addr_q.size()); end
    n_tests++; if (ack_we_q.size() != 1 || ack_we_q[0] !== 1'b1 || ack_addr_q[0] !== 32'h300) begin
      n_fail++; $display("FAIL wmiss_txn: got %0d writes expected one write to 300", ack_we_q.size());
    end
    do_access(1'b0, 32'h300, 32'h0, 0, st, rd);
    n_tests++; if (st != 5) begin n_fail++; $display("FAIL wmiss_read_stall: got %0d expected 5", st); end
    n_tests++; if (ack_addr_q.size() != 4) begin n_fail++; $display("FAIL wmiss_read_beats: got %0d expected 4", ack_addr_q.size()); end
    n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL wmiss_read_rdata: got %h expected 12345678", rd); end
  endtask

  task automatic test_reset_mid_refill();
    int          st;
    logic [31:0] rd;
    ack_delay = 0;
    ack_addr_q.delete();
    ack_we_q.delete();
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    @(negedge clk); #2;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midrst_miss_stall: got %0b expected 1", stall); end
    repeat (3) begin @(negedge clk); #2; end
    n_tests++; if (ack_addr_q.size() != 3) begin n_fail++; $display("FAIL midrst_beats_before: got %0d expected 3", ack_addr_q.size()); end
    rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %0b expected 0", mem_req); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 0", mem_addr); end
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 32'h100, 32'h0, 0, st, rd);
    n_tests++; if (st != 5) begin n_fail++; $display("FAIL midrst_reread_stall: got %0d expected 5", st); end
    n_tests++; if (ack_addr_q.size() != 4) begin n_fail++; $display("FAIL midrst_reread_beats: got %0d expected 4", ack_addr_q.size()); end
    n_tests++; if (rd !== 32'hC0DE0100) begin n_fail++; $display("FAIL midrst_reread_rdata: got %h expected c0de0100", rd); end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_write_hit();
    test_evict();
    test_write_miss();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the memory pipeline stage (ALU result as address, write data, read/write enables) and the backing data memory.
- Answers read hits combinationally in the same cycle.
- Reports misses and writes to the pipeline through `stall`, and runs multi-beat refills over a req/ack memory handshake.

Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDRESS_WIDTH`, 32: byte address width.
- `SETS`, 16: number of lines; power of two.
- `WORDS_PER_LINE`, 4: words per line; power of two, ≥2.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `cpu_re`, input, 1: load request this cycle.
- `cpu_we`, input, 1: store request this cycle; has priority if `cpu_re` is also high.
- `cpu_addr`, input, `ADDRESS_WIDTH`: byte address; bits [1:0] ignored.
- `cpu_wdata`, input, `DATA_WIDTH`: store data.
- `cpu_rdata`, output, `DATA_WIDTH`: load data; valid when `cpu_re` is high and `stall` is 0.
- `stall`, output, 1: holds all pipeline registers upstream of and including the memory stage.
- `mem_req`, output, 1: backing-memory request; registered.
- `mem_we`, output, 1: 1 for write, 0 for read; registered.
- `mem_addr`, output, `ADDRESS_WIDTH`: word-aligned byte address; registered.
- `mem_wdata`, output, `DATA_WIDTH`: write data; registered.
- `mem_rdata`, input, `DATA_WIDTH`: read data; valid in the cycle `mem_ack` is 1.
- `mem_ack`, input, 1: beat completion; only meaningful while `mem_req` is 1.

Behaviour:
- Address split:
  - offset = `addr[OB+1:2]`, where OB = log2(`WORDS_PER_LINE`).
  - index = next log2(`SETS`) bits.
  - tag = remaining upper bits.
- hit = `valid[index]` && `tag_q[index]` == tag.
- Reset (`rst` = 0, asynchronous):
  - All valid bits cleared, state = IDLE, beat counter = 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - `cpu_we`: register address and data; `mem_req`=1, `mem_we`=1 next cycle; go to WRITE; `stall`=1 this cycle.
  - `cpu_re` && hit: `cpu_rdata` = `data[index][offset]` combinationally; `stall`=0; no state change. Latency 0.
  - `cpu_re` && !hit: `stall`=1; register the line base address; beat counter = 0; go to REFILL; `mem_req`=1, `mem_we`=0, `mem_addr` = base.
  - Neither: `stall`=0 and `cpu_rdata` = 0.
- REFILL:
  - `stall`=1 in every cycle, including the final ack cycle.
  - On each `mem_ack`: write `mem_rdata` into `data[index][beat]`; increment beat; `mem_addr` = base + 4*(beat+1).
  - On the ack for beat `WORDS_PER_LINE`-1: set `valid[index]`=1 and `tag_q[index]` = tag; drop `mem_req`; go to IDLE.
  - The held request then hits on the following cycle. Miss penalty with single-cycle ack = `WORDS_PER_LINE`+1 stall cycles.
- WRITE:
  - `stall` = !`mem_ack`, so the pipeline advances exactly in the ack cycle.
  - On ack: if the registered address hits, update that cached word with the registered data; drop `mem_req`; go to IDLE.
  - A write miss never allocates.
- `mem_req` stays high, with `mem_addr`/`mem_we`/`mem_wdata` stable, until `mem_ack`. No new request is issued in the ack cycle.
- `cpu_*` inputs are sampled only in IDLE. Changes during REFILL/WRITE are ignored; the pipeline holds them stable under stall.
- Beat counter wraps modulo `WORDS_PER_LINE`. Beat and offset arithmetic is unsigned. Address increments never carry into the index field.
- Reset mid-refill: the partial line is discarded and stays invalid. `mem_req` falls asynchronously, and the memory must drop the transaction.
- `mem_ack` while `mem_req`=0 is ignored.

Decomposition:
- `cache_pkg`:
  - State enum (IDLE/REFILL/WRITE).
  - Localparams derived from parameters: OFFSET_BITS, INDEX_BITS, TAG_BITS.
  - Address-field slicing functions.
- Sub-module `cache_array`:
  - Valid/tag/data storage with combinational read port.
  - One word-write port (index, offset, data, we) and one tag/valid write port.
  - Asynchronous active-low clear of valid bits.
- `data_cache` holds the FSM, beat counter, and registered memory interface.

Test Plan:
- Reset, then read 0x100 with memory acking one cycle after each request → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C with `mem_we`=0; `stall` high 5 cycles; then `cpu_rdata` = mem[0x100], `stall`=0.
- After that refill, read 0x108 → `stall`=0 in the same cycle, `cpu_rdata` = mem[0x108], `mem_req` stays 0.
- Write 0xDEADBEEF to 0x104 with ack delayed 3 cycles → `mem_req`=1, `mem_we`=1, `mem_addr`=0x104, `mem_wdata`=0xDEADBEEF held until ack; `stall` low only in the ack cycle; next read of 0x104 hits and returns 0xDEADBEEF.
- Read 0x200 (same index 0, different tag) → miss refill of 0x200–0x20C; then read 0x100 → miss again (eviction confirmed).
- Write miss to 0x300 → one memory write, no refill beats; following read of 0x300 → miss with 4 refill beats.
- Assert `rst`=0 during beat 2 of a refill of 0x100 → `mem_req`=0 immediately; after release, read 0x100 → full 4-beat miss.
